seg_scan_wb: RTL



---
 rtl/seg_scan_wb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_wb.sv
// Wishbone-slave seven-segment controller: CPU-loaded digit patterns, autonomous
// digit multiplexing with 16-phase duty-cycle brightness and selectable polarity.
module seg_scan_wb #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 3125,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [1:0]        sel_i,
  input  logic [2:0]        adr_i,
  input  logic [15:0]       dat_i,
  output logic [15:0]       dat_o,
  output logic              ack_o,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int                PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]     PMAX    = PW'(PRESCALE - 1);
  localparam logic [2:0]        DMAX    = 3'(DIGITS - 1);
  localparam logic [2:0]        CTRL_A  = 3'd7;
  localparam logic [7:0]        SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Reset asserts asynchronously, releases two clocks after res_i rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic              r_ack;
  logic [15:0]       r_dat;
  logic [7:0]        r_seg [DIGITS];
  logic              r_en;
  logic [3:0]        r_duty;
  logic [PW-1:0]     r_presc;
  logic [3:0]        r_phase;
  logic [2:0]        r_digit;
  logic [7:0]        r_seg_o;
  logic [DIGITS-1:0] r_an_o;

  logic              w_acc;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_clear;
  logic [15:0]       w_rdata;
  logic              w_lit;
  logic [7:0]        w_cur_seg;
  logic [DIGITS-1:0] w_an;
  logic              w_unused;

  // Only the low byte lane carries writable state anywhere in the map.
  assign w_acc     = cyc_i & stb_i & ~r_ack;
  assign w_wr      = w_acc & we_i & sel_i[0];
  assign w_ctrl_wr = w_wr & (adr_i == CTRL_A);
  assign w_clear   = ~r_en | (w_ctrl_wr & ~dat_i[0]);
  assign w_unused  = &{1'b0, sel_i[1], dat_i[15:8]};

  always_comb begin
    w_rdata = 16'h0000;
    if (adr_i == CTRL_A) begin
      w_rdata = {1'b0, r_digit, 4'b0000, r_duty, 3'b000, r_en};
    end else begin
      for (int k = 0; k < DIGITS; k++)
        if (adr_i == 3'(k)) w_rdata = {8'h00, r_seg[k]};
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack  <= 1'b0;
      r_dat  <= 16'h0000;
      r_en   <= 1'b0;
      r_duty <= 4'hF;
      for (int k = 0; k < DIGITS; k++) r_seg[k] <= 8'h00;
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_dat <= w_rdata;
      if (w_wr) begin
        for (int k = 0; k < DIGITS; k++)
          if (adr_i == 3'(k)) r_seg[k] <= dat_i[7:0];
      end
      if (w_ctrl_wr) begin
        r_en   <= dat_i[0];
        r_duty <= dat_i[7:4];
      end
    end
  end

  // Counters idle at zero while disabled and clear on the edge that disables.
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc <= '0;
      r_phase <= 4'h0;
      r_digit <= 3'd0;
    end else if (w_clear) begin
      r_presc <= '0;
      r_phase <= 4'h0;
      r_digit <= 3'd0;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
      r_phase <= r_phase + 4'h1;
      if (r_phase == 4'hF)
        r_digit <= (r_digit == DMAX) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_cur_seg = 8'h00;
    w_an      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_digit == 3'(k)) begin
        w_cur_seg = r_seg[k];
        w_an[k]   = 1'b1;
      end
    end
  end

  assign w_lit = r_en & (r_phase <= r_duty);

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_seg_o <= SEG_OFF;
      r_an_o  <= AN_OFF;
    end else begin
      r_seg_o <= w_lit ? (w_cur_seg ^ SEG_OFF) : SEG_OFF;
      r_an_o  <= w_lit ? (w_an ^ AN_OFF) : AN_OFF;
    end
  end

  assign ack_o = r_ack;
  assign dat_o = r_dat;
  assign seg_o = r_seg_o;
  assign an_o  = r_an_o;

endmodule
